// File: rtl/multi_hcsr04_uc_if.sv
// Signal bundle between the HC-SR04 sequencer and its requester/datapath.
// The master side issues start requests and echoes; the slave side is the sequencer.
interface multi_hcsr04_uc_if #(
    parameter int unsigned N_CH = 4
);
    logic            medir;
    logic            modo;
    logic [2:0]      sel_canal;
    logic [N_CH-1:0] echo;
    logic            fim_medida;
    logic [N_CH-1:0] trigger;
    logic            zera;
    logic            registra;
    logic            pronto;
    logic [2:0]      canal;
    logic [N_CH-1:0] erro;
    logic [3:0]      db_estado;

    modport master (
        output medir, modo, sel_canal, echo, fim_medida,
        input  trigger, zera, registra, pronto, canal, erro, db_estado
    );

    modport slave (
        input  medir, modo, sel_canal, echo, fim_medida,
        output trigger, zera, registra, pronto, canal, erro, db_estado
    );
endinterface

// File: rtl/multi_hcsr04_uc.sv
// Control unit sequencing up to eight HC-SR04 sensors: trigger, wait for echo,
// measure, store or flag a timeout, then advance to the next channel or finish.
module multi_hcsr04_uc #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
    input logic              clock,
    input logic              reset,
    multi_hcsr04_uc_if.slave bus
);
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES
                                                                     : TRIG_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_CH      = 3'(N_CH - 1);

    typedef enum logic [3:0] {
        StIdle     = 4'h0,
        StPrep     = 4'h1,
        StTrig     = 4'h2,
        StWaitEcho = 4'h3,
        StMeasure  = 4'h4,
        StStore    = 4'h5,
        StErro     = 4'h6,
        StNext     = 4'h7,
        StDone     = 4'hF
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      canal_q, canal_d;
    logic [N_CH-1:0] erro_q, erro_d;
    logic            modo_q, modo_d;

    logic [7:0]      echo_ext;
    logic [N_CH-1:0] ch_onehot;
    logic [2:0]      start_ch;

    assign echo_ext  = 8'(bus.echo);
    assign ch_onehot = N_CH'(1) << canal_q;
    // Out-of-range channel selections fall back to channel 0.
    assign start_ch  = bus.modo ? 3'd0
                     : ((32'(bus.sel_canal) < N_CH) ? bus.sel_canal : 3'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            canal_q <= '0;
            erro_q  <= '0;
            modo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            canal_q <= canal_d;
            erro_q  <= erro_d;
            modo_q  <= modo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        canal_d = canal_q;
        erro_d  = erro_q;
        modo_d  = modo_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.medir) begin
                    state_d = StPrep;
                    canal_d = start_ch;
                    erro_d  = '0;
                    modo_d  = bus.modo;
                end
            end
            StPrep: begin
                cnt_d   = '0;
                state_d = StTrig;
            end
            StTrig: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = StWaitEcho;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitEcho: begin
                if (echo_ext[canal_q]) begin
                    cnt_d   = '0;
                    state_d = StMeasure;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = StErro;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMeasure: begin
                if (bus.fim_medida) begin
                    state_d = StStore;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = StErro;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStore: state_d = StNext;
            StErro: begin
                erro_d  = erro_q | ch_onehot;
                state_d = StNext;
            end
            StNext: begin
                // Sweep mode was latched at the start request.
                if (modo_q && (canal_q < LAST_CH)) begin
                    canal_d = canal_q + 3'd1;
                    state_d = StPrep;
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [N_CH-1:0] trigger;
    logic            zera, registra, pronto;
    logic [3:0]      db_estado;

    always_comb begin
        trigger   = '0;
        zera      = 1'b0;
        registra  = 1'b0;
        pronto    = 1'b0;
        db_estado = 4'hE;
        unique case (state_q)
            StIdle, StWaitEcho, StMeasure, StErro, StNext: db_estado = state_q;
            StPrep: begin
                zera      = 1'b1;
                db_estado = state_q;
            end
            StTrig: begin
                trigger   = ch_onehot;
                db_estado = state_q;
            end
            StStore: begin
                registra  = 1'b1;
                db_estado = state_q;
            end
            StDone: begin
                pronto    = 1'b1;
                db_estado = state_q;
            end
            default: db_estado = 4'hE;
        endcase
    end

    assign bus.trigger   = trigger;
    assign bus.zera      = zera;
    assign bus.registra  = registra;
    assign bus.pronto    = pronto;
    assign bus.canal     = canal_q;
    assign bus.erro      = erro_q;
    assign bus.db_estado = db_estado;
endmodule

// File: tb/tb_multi_hcsr04_uc.sv
// Scoreboard bench for multi_hcsr04_uc: directed scenarios push expected events,
// a negedge monitor turns DUT activity into events and compares them in order.
module tb_multi_hcsr04_uc;
    localparam int N_CH = 4;
    localparam int TRIG = 500;
    localparam int TMO  = 1000;

    localparam int EV_TRIG = 0;
    localparam int EV_REG  = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multi_hcsr04_uc_if #(.N_CH(N_CH)) ifc ();

    multi_hcsr04_uc #(
        .N_CH          (N_CH),
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void push(input int k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        exp_q.push_back(e);
    endfunction

    task automatic emit(input int k, input int a, input int b, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0d c=%0d expected none",
                     k, a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
                errors++;
                $display("FAIL event: got kind=%0d a=%0h b=%0h c=%0d expected kind=%0d a=%0h b=%0h c=%0d",
                         k, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    // Monitor: trigger pulses (value, width), registra strobes, ERRO entries
    // (channel, state left, cycles spent there) and the rising edge of pronto.
    initial begin
        int prev_st;
        int run;
        int trig_run;
        int trig_val;
        bit pr_prev;
        prev_st  = 0;
        run      = 0;
        trig_run = 0;
        trig_val = 0;
        pr_prev  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_st  = 0;
                run      = 0;
                trig_run = 0;
                pr_prev  = 1'b0;
            end else begin
                int cur;
                cur = int'(ifc.db_estado);
                if (cur == prev_st) begin
                    run++;
                end else begin
                    if (cur == 6) emit(EV_ERR, int'(ifc.canal), prev_st, run);
                    run = 1;
                end
                prev_st = cur;
                if (ifc.trigger != '0) begin
                    if (trig_run == 0) trig_val = int'(ifc.trigger);
                    trig_run++;
                end else if (trig_run > 0) begin
                    emit(EV_TRIG, trig_val, trig_run, 0);
                    trig_run = 0;
                end
                if (ifc.registra) emit(EV_REG, int'(ifc.canal), 0, 0);
                if (ifc.pronto && !pr_prev) emit(EV_DONE, int'(ifc.canal), int'(ifc.erro), 0);
                pr_prev = ifc.pronto;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_trig(input int ch, input logic level);
        int n;
        n = 0;
        while (ifc.trigger[ch] !== level && n < 4000) begin
            tick();
            n++;
        end
        check("wait_trigger", {31'd0, ifc.trigger[ch]}, {31'd0, level});
    endtask

    task automatic wait_state(input logic [3:0] st);
        int n;
        n = 0;
        while (ifc.db_estado !== st && n < 5000) begin
            tick();
            n++;
        end
        check("wait_state", ifc.db_estado, st);
    endtask

    task automatic start(input logic m, input logic [2:0] s);
        ifc.modo      = m;
        ifc.sel_canal = s;
        ifc.medir     = 1'b1;
        tick();
        ifc.medir     = 1'b0;
    endtask

    // mode: 0 normal, 1 no echo, 2 echo stuck high, 3 medir pulse in MEASURE,
    // 4 foreign echo[3] during WAIT_ECHO.
    task automatic do_channel(input int ch, input int mode);
        wait_trig(ch, 1'b1);
        wait_trig(ch, 1'b0);
        if (mode == 1) return;
        if (mode == 4) begin
            tick();
            ifc.echo[3] = 1'b1;
            repeat (5) tick();
            check("echo_other_ignored", ifc.db_estado, 4'h3);
            ifc.echo[3] = 1'b0;
            repeat (14) tick();
        end else begin
            repeat (20) tick();
        end
        ifc.echo[ch] = 1'b1;
        if (mode == 2) begin
            wait_state(4'h6);
            ifc.echo[ch] = 1'b0;
            return;
        end
        if (mode == 3) begin
            repeat (10) tick();
            ifc.medir = 1'b1;
            tick();
            ifc.medir = 1'b0;
            repeat (5) tick();
            check("medir_ignored", ifc.db_estado, 4'h4);
            repeat (84) tick();
        end else begin
            repeat (100) tick();
        end
        ifc.fim_medida = 1'b1;
        tick();
        ifc.fim_medida = 1'b0;
        ifc.echo[ch]   = 1'b0;
    endtask

    task automatic finish_run();
        wait_state(4'hF);
        tick();
        tick();
    endtask

    initial begin
        ifc.medir      = 1'b0;
        ifc.modo       = 1'b0;
        ifc.sel_canal  = 3'd0;
        ifc.echo       = '0;
        ifc.fim_medida = 1'b0;
        #1;
        check("rst_state", ifc.db_estado, 4'h0);
        check("rst_trigger", ifc.trigger, 0);
        check("rst_strobes", {ifc.zera, ifc.registra, ifc.pronto}, 0);
        check("rst_canal", ifc.canal, 0);
        check("rst_erro", ifc.erro, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        check("idle_hold", ifc.db_estado, 4'h0);

        // Single channel 2
        push(EV_TRIG, 4'b0100, TRIG, 0);
        push(EV_REG, 2, 0, 0);
        push(EV_DONE, 2, 0, 0);
        start(1'b0, 3'd2);
        do_channel(2, 0);
        finish_run();
        check("single_pronto", {31'd0, ifc.pronto}, 1);
        check("single_canal", ifc.canal, 2);
        check("single_erro", ifc.erro, 0);

        // Out-of-range selection maps to channel 0
        push(EV_TRIG, 4'b0001, TRIG, 0);
        push(EV_REG, 0, 0, 0);
        push(EV_DONE, 0, 0, 0);
        start(1'b0, 3'd6);
        do_channel(0, 0);
        finish_run();

        // Full sweep, sel_canal irrelevant
        for (int ch = 0; ch < N_CH; ch++) begin
            push(EV_TRIG, 1 << ch, TRIG, 0);
            push(EV_REG, ch, 0, 0);
        end
        push(EV_DONE, 3, 0, 0);
        start(1'b1, 3'd2);
        for (int ch = 0; ch < N_CH; ch++) do_channel(ch, 0);
        finish_run();

        // Sweep with channel 1 silent
        push(EV_TRIG, 4'b0001, TRIG, 0);
        push(EV_REG, 0, 0, 0);
        push(EV_TRIG, 4'b0010, TRIG, 0);
        push(EV_ERR, 1, 3, TMO);
        push(EV_TRIG, 4'b0100, TRIG, 0);
        push(EV_REG, 2, 0, 0);
        push(EV_TRIG, 4'b1000, TRIG, 0);
        push(EV_REG, 3, 0, 0);
        push(EV_DONE, 3, 4'b0010, 0);
        start(1'b1, 3'd0);
        do_channel(0, 0);
        do_channel(1, 1);
        do_channel(2, 0);
        do_channel(3, 0);
        finish_run();
        check("timeout_erro", ifc.erro, 4'b0010);

        // Echo stuck high, no end-of-measure
        push(EV_TRIG, 4'b0001, TRIG, 0);
        push(EV_ERR, 0, 4, TMO);
        push(EV_DONE, 0, 4'b0001, 0);
        start(1'b0, 3'd0);
        do_channel(0, 2);
        finish_run();
        check("stuck_erro", ifc.erro, 4'b0001);

        // Sweep with ignored inputs; modo dropped after start must not stop it
        for (int ch = 0; ch < N_CH; ch++) begin
            push(EV_TRIG, 1 << ch, TRIG, 0);
            push(EV_REG, ch, 0, 0);
        end
        push(EV_DONE, 3, 0, 0);
        start(1'b1, 3'd0);
        ifc.modo = 1'b0;
        do_channel(0, 3);
        do_channel(1, 4);
        do_channel(2, 0);
        do_channel(3, 0);
        finish_run();

        // Reset in the middle of a trigger pulse
        start(1'b0, 3'd1);
        wait_trig(1, 1'b1);
        repeat (199) tick();
        check("pre_reset_trigger", ifc.trigger, 4'b0010);
        reset = 1'b0;
        #1;
        check("mid_rst_trigger", ifc.trigger, 0);
        check("mid_rst_state", ifc.db_estado, 4'h0);
        check("mid_rst_canal", ifc.canal, 0);
        check("mid_rst_strobes", {ifc.zera, ifc.registra, ifc.pronto}, 0);
        check("mid_rst_erro", ifc.erro, 0);
        tick();
        push(EV_TRIG, 4'b0010, TRIG, 0);
        push(EV_REG, 1, 0, 0);
        push(EV_DONE, 1, 0, 0);
        ifc.modo      = 1'b0;
        ifc.sel_canal = 3'd1;
        ifc.medir     = 1'b1;
        reset         = 1'b1;
        tick();
        ifc.medir = 1'b0;
        check("first_edge_after_reset", ifc.db_estado, 4'h1);
        check("zera_in_prep", {31'd0, ifc.zera}, 1);
        do_channel(1, 0);
        finish_run();

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
